fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT control.
// Optional fetch counter port enabled by defining FETCH_STATS_EN.
module fetch_unit #(
  parameter logic [5:0] RESET_PC = 6'd0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [5:0]       redirect_addr,
  input  logic             halt_req,
  output logic [5:0]       imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      id_instr,
  output logic [5:0]       id_pc_next,
  output logic             id_valid,
`ifdef FETCH_STATS_EN
  output logic [CNT_W-1:0] fetch_count,
`endif
  output logic             halted
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [5:0]  r_pc;
  logic [31:0] r_id_instr;
  logic [5:0]  r_id_pc_next;
  logic        r_id_valid;
  logic        r_halted;
  logic [5:0]  w_pc_inc;
  logic        w_fetch;

  // 6-bit addition wraps 63 -> 0 naturally.
  assign w_pc_inc = r_pc + 6'd1;

  // A real instruction is captured only in RUN with no redirect, halt or stall.
  assign w_fetch = (r_state == S_RUN) && !redirect && !halt_req && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_id_instr   <= '0;
      r_id_pc_next <= '0;
      r_id_valid   <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_id_valid <= 1'b0;
          r_halted   <= 1'b0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (redirect) begin
            r_pc       <= redirect_addr;
            r_id_valid <= 1'b0;
            if (halt_req) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end else if (halt_req) begin
            r_id_valid <= 1'b0;
            r_state    <= S_HALT;
            r_halted   <= 1'b1;
          end else if (!stall) begin
            r_id_instr   <= imem_data;
            r_id_pc_next <= w_pc_inc;
            r_id_valid   <= 1'b1;
            r_pc         <= w_pc_inc;
          end
        end
        S_HALT: begin
          r_id_valid <= 1'b0;
          if (redirect) begin
            r_pc     <= redirect_addr;
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_BOOT;
          r_id_valid <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [CNT_W-1:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_fetch) begin
      r_fetch_count <= r_fetch_count + 1'b1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

  assign imem_addr  = r_pc;
  assign id_instr   = r_id_instr;
  assign id_pc_next = r_id_pc_next;
  assign id_valid   = r_id_valid;
  assign halted     = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random control traffic,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int unsigned CNT_W = 16;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [5:0]  redirect_addr;
  logic        halt_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_instr;
  logic [5:0]  id_pc_next;
  logic        id_valid;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [CNT_W-1:0] fetch_count;
`endif

  logic [31:0] mem [64];

  int unsigned n_cmp;
  int unsigned n_bad;

  // Reference model state
  int unsigned m_pc;
  bit          m_booting;
  bit          m_halted;
  logic [31:0] m_instr;
  int unsigned m_pcn;
  bit          m_valid;
  int unsigned m_cnt;

  fetch_unit #(.RESET_PC(6'd0), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt_req      (halt_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .id_instr      (id_instr),
    .id_pc_next    (id_pc_next),
    .id_valid      (id_valid),
`ifdef FETCH_STATS_EN
    .fetch_count   (fetch_count),
`endif
    .halted        (halted)
  );

  assign imem_data = mem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 0;
    m_booting = 1;
    m_halted  = 0;
    m_instr   = 32'h0;
    m_pcn     = 0;
    m_valid   = 0;
    m_cnt     = 0;
  endtask

  // Applies the fetch rules for one rising edge, using the inputs present before the edge.
  task automatic model_edge();
    if (m_booting) begin
      m_booting = 0;
      m_valid   = 0;
    end else if (m_halted) begin
      m_valid = 0;
      if (redirect) begin
        m_pc     = redirect_addr;
        m_halted = 0;
      end
    end else if (redirect) begin
      m_pc    = redirect_addr;
      m_valid = 0;
      if (halt_req) m_halted = 1;
    end else if (halt_req) begin
      m_halted = 1;
      m_valid  = 0;
    end else if (!stall) begin
      m_instr = mem[m_pc];
      m_pcn   = (m_pc + 1) % 64;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 64;
      m_cnt   = (m_cnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
    cmp({tag, ".id_valid"}, 32'(id_valid), 32'(m_valid));
    cmp({tag, ".halted"}, 32'(halted), 32'(m_halted));
    cmp({tag, ".id_instr"}, id_instr, m_instr);
    cmp({tag, ".id_pc_next"}, 32'(id_pc_next), 32'(m_pcn));
`ifdef FETCH_STATS_EN
    cmp({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_cnt));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit s, input bit r, input int unsigned ra, input bit h);
    stall         = s;
    redirect      = r;
    redirect_addr = 6'(ra);
    halt_req      = h;
  endtask

  // Asserts reset away from the clock edge and checks the outputs clear without a clock.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    set_in(0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h20020005;
    rst_n = 1'b1;
    set_in(1, 1, 33, 1);
    model_reset();
    #3;

    pulse_reset("rst0");

    // Reset release: one bubble, then word 0
    step("boot");
    cmp("boot.bubble", 32'(id_valid), 32'd0);
    step("first");
    cmp("first.instr", id_instr, 32'h20020005);
    cmp("first.pcn", 32'(id_pc_next), 32'd1);
    cmp("first.valid", 32'(id_valid), 32'd1);

    // Wrap from 62
    set_in(0, 1, 62, 0);
    step("to62");
    set_in(0, 0, 0, 0);
    step("wrap0");
    cmp("wrap0.pcn", 32'(id_pc_next), 32'd63);
    cmp("wrap0.instr", id_instr, mem[62]);
    step("wrap1");
    cmp("wrap1.pcn", 32'(id_pc_next), 32'd0);
    cmp("wrap1.instr", id_instr, mem[63]);
    step("wrap2");
    cmp("wrap2.pcn", 32'(id_pc_next), 32'd1);
    cmp("wrap2.instr", id_instr, mem[0]);

    // Stall at PC=5
    set_in(0, 1, 5, 0);
    step("to5");
    set_in(0, 0, 0, 0);
    step("pre_stall");
    set_in(0, 1, 5, 0);
    step("re5");
    set_in(1, 0, 0, 0);
    step("stall1");
    cmp("stall1.addr", 32'(imem_addr), 32'd5);
    step("stall2");
    cmp("stall2.addr", 32'(imem_addr), 32'd5);
    set_in(0, 0, 0, 0);
    step("unstall");
    cmp("unstall.instr", id_instr, mem[5]);

    // Redirect overrides stall
    set_in(1, 1, 15, 0);
    step("redir15");
    cmp("redir15.valid", 32'(id_valid), 32'd0);
    cmp("redir15.addr", 32'(imem_addr), 32'd15);
    set_in(0, 0, 0, 0);
    step("after15");
    cmp("after15.instr", id_instr, mem[15]);

    // Halt at 7, redirect to 14 three cycles later
    set_in(0, 1, 7, 0);
    step("to7");
    set_in(0, 0, 0, 1);
    step("halt0");
    cmp("halt0.halted", 32'(halted), 32'd1);
    cmp("halt0.addr", 32'(imem_addr), 32'd7);
    set_in(1, 0, 0, 1);
    step("halt1");
    set_in(0, 0, 0, 0);
    step("halt2");
    cmp("halt2.addr", 32'(imem_addr), 32'd7);
    set_in(0, 1, 14, 0);
    step("resume");
    cmp("resume.halted", 32'(halted), 32'd0);
    set_in(0, 0, 0, 0);
    step("after14");
    cmp("after14.instr", id_instr, mem[14]);
    cmp("after14.valid", 32'(id_valid), 32'd1);

    // Redirect and halt together
    set_in(0, 1, 40, 1);
    step("redir_halt");
    cmp("redir_halt.addr", 32'(imem_addr), 32'd40);
    cmp("redir_halt.halted", 32'(halted), 32'd1);
    set_in(0, 1, 20, 0);
    step("out_halt");

    // Counter scenario: 10 fetches, 1 flush, 2 stalls
    #1;
    pulse_reset("rst1");
    step("boot1");
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("run10");
    set_in(0, 1, 3, 0);
    step("flush");
    set_in(1, 0, 0, 0);
    step("stA");
    step("stB");
`ifdef FETCH_STATS_EN
    cmp("count10", 32'(fetch_count), 32'd10);
`endif
    set_in(0, 0, 0, 0);
    step("run_more");
    #2;
    pulse_reset("rst_mid");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 63), $urandom_range(0, 19) == 0);
      step("rand");
      if (i == 200) begin
        set_in(1, 1, 9, 1);
        #2;
        pulse_reset("rst_rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
